// File: rtl/gate_tester.sv
// Stimulus/response self-test for a two-input, six-function gate unit.
// Walks {a,b} through 00..11, samples the synchronized response and flags mismatching functions.
module gate_tester #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:0] y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] fail_mask,
   output logic [1:0] first_fail
);

   typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

   localparam logic [7:0] CntReload = 8'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] combo_q, combo_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] sync1_q, sync2_q;
   logic [5:0] fail_mask_q, fail_mask_d;
   logic [1:0] first_fail_q, first_fail_d;
   logic       seen_q, seen_d;
   logic       pass_q, pass_d;
   logic [5:0] exp_y;
   logic [5:0] diff;

   // Expected {xnor, xor, nor, or, nand, and} for the current combination.
   always_comb begin
      exp_y = 6'b101010;
      unique case (combo_q)
         2'd0: exp_y = 6'b101010;
         2'd1: exp_y = 6'b010110;
         2'd2: exp_y = 6'b010110;
         2'd3: exp_y = 6'b100101;
         default: exp_y = 6'b101010;
      endcase
   end

   assign diff = sync2_q ^ exp_y;

   always_comb begin
      state_d      = state_q;
      combo_d      = combo_q;
      cnt_d        = cnt_q;
      fail_mask_d  = fail_mask_q;
      first_fail_d = first_fail_q;
      seen_d       = seen_q;
      pass_d       = pass_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d      = StSettle;
               combo_d      = 2'd0;
               cnt_d        = CntReload;
               fail_mask_d  = 6'd0;
               first_fail_d = 2'd0;
               seen_d       = 1'b0;
               pass_d       = 1'b0;
            end
         end
         StSettle: begin
            if (cnt_q == 8'd0) begin
               state_d = StCheck;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StCheck: begin
            fail_mask_d = fail_mask_q | diff;
            if ((diff != 6'd0) && !seen_q) begin
               first_fail_d = combo_q;
               seen_d       = 1'b1;
            end
            if (combo_q == 2'd3) begin
               state_d = StDone;
               // Use the mask including this final check so pass is valid alongside done.
               pass_d  = (fail_mask_d == 6'd0);
            end else begin
               state_d = StSettle;
               combo_d = combo_q + 2'd1;
               cnt_d   = CntReload;
            end
         end
         StDone: begin
            state_d = StIdle;
            combo_d = 2'd0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         combo_q      <= 2'd0;
         cnt_q        <= 8'd0;
         fail_mask_q  <= 6'd0;
         first_fail_q <= 2'd0;
         seen_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         combo_q      <= combo_d;
         cnt_q        <= cnt_d;
         fail_mask_q  <= fail_mask_d;
         first_fail_q <= first_fail_d;
         seen_q       <= seen_d;
         pass_q       <= pass_d;
      end
   end

   // The response may come from an unclocked lab board, hence two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 6'd0;
         sync2_q <= 6'd0;
      end else begin
         sync1_q <= y_in;
         sync2_q <= sync1_q;
      end
   end

   assign a_out      = combo_q[1];
   assign b_out      = combo_q[0];
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign pass       = pass_q;
   assign fail_mask  = fail_mask_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: ideal and faulty gate models, restart, reset abort,
// and a minimum-settle instance driven through a one-cycle-delayed model.
module tb_gate_tester;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start3 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [5:0] y_in, y3_in;
   logic       a_out, b_out, busy, done, pass;
   logic [5:0] fail_mask;
   logic [1:0] first_fail;
   logic       a3, b3, busy3, done3, pass3;
   logic [5:0] fail_mask3;
   logic [1:0] first_fail3;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   function automatic logic [5:0] gate(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
   endfunction

   always_comb begin
      y_in = gate(a_out, b_out);
      if (mode == 2'd1) y_in[4] = 1'b0;
      if (mode == 2'd2) y_in[5] = ~y_in[5];
   end

   always @(posedge clk) y3_in <= gate(a3, b3);

   gate_tester dut (
      .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
      .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
      .fail_mask(fail_mask), .first_fail(first_fail)
   );

   gate_tester #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .y_in(y3_in),
      .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
      .fail_mask(fail_mask3), .first_fail(first_fail3)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full run with a one-cycle start pulse; edge numbers are relative to the start sample.
   task automatic do_run(input logic [5:0] em, input logic [1:0] ef, input logic ep);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("busy_e1", 8'(busy), 8'd1);
      chk("ab_e1", 8'({a_out, b_out}), 8'd0);
      step(4);
      chk("ab_e5", 8'({a_out, b_out}), 8'd0);
      step(1);
      chk("ab_e6", 8'({a_out, b_out}), 8'd1);
      step(5);
      chk("ab_e11", 8'({a_out, b_out}), 8'd2);
      step(5);
      chk("ab_e16", 8'({a_out, b_out}), 8'd3);
      step(4);
      chk("done_e20", 8'(done), 8'd0);
      step(1);
      chk("done_e21", 8'(done), 8'd1);
      chk("busy_e21", 8'(busy), 8'd1);
      chk("pass_e21", 8'(pass), 8'(ep));
      chk("mask_e21", 8'(fail_mask), 8'(em));
      chk("ff_e21", 8'(first_fail), 8'(ef));
      step(1);
      chk("done_e22", 8'(done), 8'd0);
      chk("busy_e22", 8'(busy), 8'd0);
      chk("ab_e22", 8'({a_out, b_out}), 8'd0);
      chk("pass_held", 8'(pass), 8'(ep));
      chk("mask_held", 8'(fail_mask), 8'(em));
   endtask

   initial begin
      int n_done;
      int done_edge;

      // Reset state
      step(2);
      chk("rst_outs", 8'({a_out, b_out, busy, done, pass}), 8'd0);
      chk("rst_mask", 8'(fail_mask), 8'd0);
      chk("rst_ff", 8'(first_fail), 8'd0);
      rst_n = 1'b1;
      step(2);

      mode = 2'd0;
      do_run(6'b000000, 2'd0, 1'b1);
      mode = 2'd1;
      do_run(6'b010000, 2'd1, 1'b0);
      mode = 2'd2;
      do_run(6'b100000, 2'd0, 1'b0);
      mode = 2'd0;
      do_run(6'b000000, 2'd0, 1'b1);

      // Extra start pulses mid-run must not restart it
      start = 1'b1;
      step(1);
      start = 1'b0;
      n_done = 0;
      done_edge = 0;
      for (int e = 2; e <= 30; e++) begin
         start = (e == 4 || e == 11);
         step(1);
         if (done) begin
            n_done++;
            done_edge = e;
         end
      end
      start = 1'b0;
      chk("restart_ndone", 8'(n_done), 8'd1);
      chk("restart_edge", 8'(done_edge), 8'd21);
      chk("restart_pass", 8'(pass), 8'd1);

      // Reset mid-run
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(11);
      chk("pre_abort_busy", 8'(busy), 8'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", 8'({a_out, b_out, busy, done, pass}), 8'd0);
      chk("abort_mask", 8'({fail_mask, first_fail}), 8'd0);
      n_done = 0;
      for (int e = 0; e < 2; e++) begin
         step(1);
         if (done) n_done++;
      end
      rst_n = 1'b1;
      for (int e = 0; e < 25; e++) begin
         step(1);
         if (done || busy) n_done++;
      end
      chk("abort_nodone", 8'(n_done), 8'd0);
      do_run(6'b000000, 2'd0, 1'b1);

      // Minimum settle with a one-cycle-late response
      start3 = 1'b1;
      step(1);
      start3 = 1'b0;
      done_edge = 0;
      for (int e = 2; e <= 25; e++) begin
         step(1);
         if (done3 && done_edge == 0) begin
            done_edge = e;
            chk("s3_pass", 8'(pass3), 8'd1);
            chk("s3_mask", 8'({fail_mask3, first_fail3}), 8'd0);
         end
      end
      chk("s3_done_edge", 8'(done_edge), 8'd17);
      chk("s3_idle", 8'(busy3), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
